// File: rtl/rs_regfile_pkg.sv
// Shared tag constants and reservation-station IDs for the register-status table.
package rs_pkg;

  localparam int TAG_W_DEF = 4;

  localparam logic [TAG_W_DEF-1:0] TAG_NONE = 4'd0;
  localparam logic [TAG_W_DEF-1:0] ADD_0    = 4'd1;
  localparam logic [TAG_W_DEF-1:0] ADD_1    = 4'd2;
  localparam logic [TAG_W_DEF-1:0] MULT_0   = 4'd3;
  localparam logic [TAG_W_DEF-1:0] MULT_1   = 4'd4;
  localparam logic [TAG_W_DEF-1:0] FETCH_0  = 4'd5;
  localparam logic [TAG_W_DEF-1:0] FETCH_1  = 4'd6;
  localparam logic [TAG_W_DEF-1:0] STORE_0  = 4'd7;
  localparam logic [TAG_W_DEF-1:0] STORE_1  = 4'd8;

endpackage

// File: rtl/rs_regfile_cdb_match.sv
// Priority match of one waiting tag against all CDB channels; lowest channel wins,
// and a zero tag never matches.
module cdb_match #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8,
  parameter int NCDB   = 3
) (
  input  logic [TAG_W-1:0]       tag,
  input  logic [NCDB-1:0]        cdb_vld,
  input  logic [NCDB*TAG_W-1:0]  cdb_tag,
  input  logic [NCDB*DATA_W-1:0] cdb_data,
  output logic                   hit,
  output logic [DATA_W-1:0]      data
);

  // Scan from the highest channel down so the lowest matching channel is written last.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int c = NCDB - 1; c >= 0; c--) begin
      if (cdb_vld[c] && (tag != '0) && (cdb_tag[c*TAG_W +: TAG_W] == tag)) begin
        hit  = 1'b1;
        data = cdb_data[c*DATA_W +: DATA_W];
      end else begin
        hit  = hit;
        data = data;
      end
    end
  end

endmodule

// File: rtl/rs_regfile.sv
// Register file with rename-tag table, CDB capture and dual-issue operand lookup.
// Optional same-cycle CDB bypass on operand reads: RS_REGFILE_BYPASS_EN.
module rs_regfile
  import rs_pkg::*;
#(
  parameter int NREG   = 4,
  parameter int DATA_W = 8,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int NCDB   = 3,
  localparam int RW    = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             iss_vld,
  input  logic [2*RW-1:0]        iss_dst,
  input  logic [2*TAG_W-1:0]     iss_tag,
  input  logic [4*RW-1:0]        src_idx,
  output logic [4*DATA_W-1:0]    src_val,
  output logic [4*TAG_W-1:0]     src_tag,
  output logic [3:0]             src_rdy,
  input  logic [NCDB-1:0]        cdb_vld,
  input  logic [NCDB*TAG_W-1:0]  cdb_tag,
  input  logic [NCDB*DATA_W-1:0] cdb_data,
  output logic [NREG*DATA_W-1:0] regs
);

  logic [DATA_W-1:0] val_q [NREG];
  logic [DATA_W-1:0] val_d [NREG];
  logic [TAG_W-1:0]  tag_q [NREG];
  logic [TAG_W-1:0]  tag_d [NREG];
  logic [NREG-1:0]   cap_hit;
  logic [DATA_W-1:0] cap_data [NREG];
  logic [RW-1:0]     op_idx [4];

  for (genvar g = 0; g < NREG; g++) begin : g_match
    cdb_match #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NCDB(NCDB)) u_match (
      .tag      (tag_q[g]),
      .cdb_vld  (cdb_vld),
      .cdb_tag  (cdb_tag),
      .cdb_data (cdb_data),
      .hit      (cap_hit[g]),
      .data     (cap_data[g])
    );
  end

  // Next state: capture first, then renames (slot 1 last) or flush override the tag.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      val_d[r] = val_q[r];
      tag_d[r] = tag_q[r];
      if (cap_hit[r]) begin
        val_d[r] = cap_data[r];
        tag_d[r] = '0;
      end else begin
        val_d[r] = val_q[r];
      end
      if (flush) begin
        tag_d[r] = '0;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (iss_vld[s] && (iss_dst[s*RW +: RW] == RW'(r))) begin
            tag_d[r] = iss_tag[s*TAG_W +: TAG_W];
          end else begin
            tag_d[r] = tag_d[r];
          end
        end
      end
    end
  end

  // State registers with synchronous reset to all-ready, all-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= val_d[r];
        tag_q[r] <= tag_d[r];
      end
    end
  end

  // Flatten register values, register 0 in the LSBs.
  always_comb begin
    regs = '0;
    for (int r = 0; r < NREG; r++) begin
      regs[r*DATA_W +: DATA_W] = val_q[r];
    end
  end

  // Operand lookup; operands 2 and 3 belong to slot 1 and see slot 0's rename.
  always_comb begin
    src_val = '0;
    src_tag = '0;
    src_rdy = '0;
    for (int i = 0; i < 4; i++) begin
      op_idx[i] = src_idx[i*RW +: RW];
      src_val[i*DATA_W +: DATA_W] = val_q[op_idx[i]];
      src_tag[i*TAG_W +: TAG_W]   = tag_q[op_idx[i]];
      if ((i >= 2) && iss_vld[0] && (iss_dst[RW-1:0] == op_idx[i])) begin
        src_rdy[i] = 1'b0;
        src_tag[i*TAG_W +: TAG_W] = iss_tag[TAG_W-1:0];
`ifdef RS_REGFILE_BYPASS_EN
      end else if (cap_hit[op_idx[i]]) begin
        src_rdy[i] = 1'b1;
        src_val[i*DATA_W +: DATA_W] = cap_data[op_idx[i]];
        src_tag[i*TAG_W +: TAG_W]   = '0;
`endif
      end else if (tag_q[op_idx[i]] == '0) begin
        src_rdy[i] = 1'b1;
        src_tag[i*TAG_W +: TAG_W] = '0;
      end else begin
        src_rdy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_regfile.sv
// Randomized and directed bench for rs_regfile against an array-based reference model.
module tb_rs_regfile;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  iss_vld;
  logic [3:0]  iss_dst;
  logic [7:0]  iss_tag;
  logic [7:0]  src_idx;
  logic [31:0] src_val;
  logic [15:0] src_tag;
  logic [3:0]  src_rdy;
  logic [2:0]  cdb_vld;
  logic [11:0] cdb_tag;
  logic [23:0] cdb_data;
  logic [31:0] regs;

  logic [7:0] mval [4];
  logic [3:0] mtag [4];
  int n_chk = 0;
  int n_fail = 0;

  rs_regfile dut (
    .clk(clk), .rst(rst), .flush(flush), .iss_vld(iss_vld), .iss_dst(iss_dst),
    .iss_tag(iss_tag), .src_idx(src_idx), .src_val(src_val), .src_tag(src_tag),
    .src_rdy(src_rdy), .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .regs(regs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic idle(input logic [7:0] idx);
    flush = 1'b0; iss_vld = 2'b00; iss_dst = 4'd0; iss_tag = 8'd0;
    cdb_vld = 3'b000; cdb_tag = 12'd0; cdb_data = 24'd0; src_idx = idx;
  endtask

  // Check all outputs against the model, then advance the model by one clock.
  task automatic step();
    logic [1:0] idx;
    logic       er, bh;
    logic [7:0] ev, bd;
    logic [3:0] et;
    logic [7:0] nval [4];
    logic [3:0] ntag [4];
    #1;
    for (int i = 0; i < 4; i++) begin
      idx = src_idx[i*2 +: 2];
      er = 1'b0; ev = mval[idx]; et = mtag[idx];
      bh = 1'b0; bd = 8'd0;
`ifdef RS_REGFILE_BYPASS_EN
      for (int c = 0; c < 3; c++)
        if (!bh && cdb_vld[c] && mtag[idx] != 4'd0 && cdb_tag[c*4 +: 4] == mtag[idx]) begin
          bh = 1'b1; bd = cdb_data[c*8 +: 8];
        end
`endif
      if (i >= 2 && iss_vld[0] && iss_dst[1:0] == idx) begin
        er = 1'b0; et = iss_tag[3:0];
      end else if (bh) begin
        er = 1'b1; ev = bd;
      end else if (mtag[idx] == 4'd0) begin
        er = 1'b1;
      end
      check($sformatf("rdy%0d", i), 32'(src_rdy[i]), 32'(er));
      if (er) begin
        check($sformatf("val%0d", i), 32'(src_val[i*8 +: 8]), 32'(ev));
        check($sformatf("tag0_%0d", i), 32'(src_tag[i*4 +: 4]), 32'd0);
      end else begin
        check($sformatf("tag%0d", i), 32'(src_tag[i*4 +: 4]), 32'(et));
      end
    end
    for (int r = 0; r < 4; r++) check($sformatf("regs%0d", r), 32'(regs[r*8 +: 8]), 32'(mval[r]));
    for (int r = 0; r < 4; r++) begin
      nval[r] = mval[r]; ntag[r] = mtag[r];
      if (mtag[r] != 4'd0) begin
        for (int c = 2; c >= 0; c--)
          if (cdb_vld[c] && cdb_tag[c*4 +: 4] == mtag[r]) begin
            nval[r] = cdb_data[c*8 +: 8]; ntag[r] = 4'd0;
          end
      end
    end
    if (flush) begin
      for (int r = 0; r < 4; r++) ntag[r] = 4'd0;
    end else begin
      if (iss_vld[0]) ntag[iss_dst[1:0]] = iss_tag[3:0];
      if (iss_vld[1]) ntag[iss_dst[3:2]] = iss_tag[7:4];
    end
    @(posedge clk);
    for (int r = 0; r < 4; r++) begin mval[r] = nval[r]; mtag[r] = ntag[r]; end
    @(negedge clk);
  endtask

  function automatic logic [3:0] fresh_tag(input logic [3:0] avoid);
    logic [3:0] t;
    logic used;
    for (int k = 0; k < 200; k++) begin
      t = 4'($urandom_range(1, 15));
      used = (t == avoid);
      for (int r = 0; r < 4; r++) used = used | (mtag[r] == t);
      if (!used) return t;
    end
    return 4'd15;
  endfunction

  task automatic rand_inputs();
    logic [3:0] t0, t1;
    flush   = ($urandom_range(0, 19) == 0);
    iss_vld = 2'($urandom);
    iss_dst = 4'($urandom);
    t0 = fresh_tag(4'd0);
    t1 = fresh_tag(t0);
    iss_tag = {t1, t0};
    src_idx = 8'($urandom);
    cdb_vld = 3'($urandom);
    cdb_data = 24'($urandom);
    for (int c = 0; c < 3; c++)
      cdb_tag[c*4 +: 4] = ($urandom_range(0, 9) < 7) ? mtag[$urandom_range(0, 3)]
                                                      : 4'($urandom);
  endtask

  initial begin
    idle(8'b11_10_01_00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin mval[r] = 8'd0; mtag[r] = 4'd0; end
    check("reset_regs", regs, 32'd0);
    step();

    // r2 renamed to tag 1, then captured from ch0.
    idle(8'b11_10_01_00); iss_vld = 2'b01; iss_dst = 4'd2; iss_tag = 8'd1; step();
    idle(8'b10_10_10_10); step();
    idle(8'b10_10_10_10); cdb_vld = 3'b001; cdb_tag = 12'd1; cdb_data = 24'h5A; step();
    idle(8'b10_10_10_10); #1;
    check("r2_after_cap_rdy", 32'(src_rdy[0]), 32'd1);
    check("r2_after_cap_val", 32'(src_val[7:0]), 32'h5A);
    step();

    // Intra-pair dependency, then same-destination pair.
    idle(8'b01_01_00_00); iss_vld = 2'b01; iss_dst = 4'd1; iss_tag = 8'd3; #1;
    check("pair_dep_rdy", 32'(src_rdy[2]), 32'd0);
    check("pair_dep_tag", 32'(src_tag[11:8]), 32'd3);
    step();
    idle(8'b00_00_00_00); iss_vld = 2'b11; iss_dst = 4'b11_11; iss_tag = 8'h65; step();
    idle(8'b11_11_11_11); #1;
    check("r3_slot1_wins", 32'(src_tag[3:0]), 32'd6);
    step();

    // Rename and capture on r0 in the same cycle.
    idle(8'd0); iss_vld = 2'b01; iss_dst = 4'd0; iss_tag = 8'd2; step();
    idle(8'd0); cdb_vld = 3'b010; cdb_tag = 12'h020; cdb_data = 24'h001100;
    iss_vld = 2'b01; iss_dst = 4'd0; iss_tag = 8'd4; step();
    idle(8'd0); #1;
    check("r0_cap_val", 32'(regs[7:0]), 32'h11);
    check("r0_rename_tag", 32'(src_tag[3:0]), 32'd4);
    step();

    // Capture while reading r1 (bypass-dependent).
    idle(8'd0); iss_vld = 2'b01; iss_dst = 4'd1; iss_tag = 8'd7; step();
    idle(8'b01_01_01_01); cdb_vld = 3'b100; cdb_tag = 12'h700; cdb_data = 24'h330000; #1;
`ifdef RS_REGFILE_BYPASS_EN
    check("bypass_rdy", 32'(src_rdy[0]), 32'd1);
    check("bypass_val", 32'(src_val[7:0]), 32'h33);
`else
    check("nobypass_rdy", 32'(src_rdy[0]), 32'd0);
    check("nobypass_tag", 32'(src_tag[3:0]), 32'd7);
`endif
    step();
    idle(8'b01_01_01_01); step();

    // Flush with pending tags and a concurrent rename.
    idle(8'd0); iss_vld = 2'b11; iss_dst = 4'b10_01; iss_tag = 8'h98; step();
    idle(8'b11_10_01_00); flush = 1'b1; iss_vld = 2'b11; iss_dst = 4'b01_00; iss_tag = 8'hBA;
    step();
    idle(8'b11_10_01_00); #1;
    check("flush_all_rdy", 32'(src_rdy), 32'hF);
    step();

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
